prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 153 +++++++++++++++
 tb/tb_prog_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer: registered program counter with program-load, branch, call/return
// (bounded return-address stack) and halt control, one action per cycle.
module prog_sequencer #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned NUM_PROGS = 3,
    parameter logic [NUM_PROGS-1:0][PC_W-1:0] START_TABLE =
        {PC_W'(256), PC_W'(128), PC_W'(0)},
    localparam int unsigned SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int unsigned IDX_W = $clog2(RAS_DEPTH),
    localparam int unsigned LVL_W = $clog2(RAS_DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             Stall,
    input  logic             BranchAbs,
    input  logic             BranchRel,
    input  logic             Call,
    input  logic             Ret,
    input  logic             Halt,
    input  logic             ALU_flag,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic             StackErr,
    output logic [LVL_W-1:0] StackLvl
);

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StHalt
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_pc_rel;
    logic [PC_W-1:0]  w_load_pc;
    logic [PC_W-1:0]  w_top;
    logic [LVL_W-1:0] r_lvl;
    logic [LVL_W-1:0] w_lvl_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];

    // Offset addition wraps naturally at PC_W bits, giving two's-complement relative branches.
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_rel = r_pc + Target;
    assign w_empty  = (r_lvl == '0);
    assign w_full   = (r_lvl == LVL_W'(RAS_DEPTH));
    assign w_wr_idx = r_lvl[IDX_W-1:0];
    assign w_rd_idx = w_wr_idx - IDX_W'(1);
    assign w_top    = r_ras[w_rd_idx];

    // Out-of-range selections fall back to program 0.
    always_comb begin
        w_load_pc = START_TABLE[0];
        for (int i = 1; i < NUM_PROGS; i++) begin
            if (ProgSel == SEL_W'(i)) begin
                w_load_pc = START_TABLE[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lvl_nxt   = r_lvl;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        if (Start) begin
            w_state_nxt = StLoad;
            w_pc_nxt    = w_load_pc;
            w_lvl_nxt   = '0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                StLoad: w_state_nxt = StRun;
                StHalt: w_state_nxt = StHalt;
                StRun: begin
                    if (Stall) begin
                        w_state_nxt = StRun;
                    end else if (Halt) begin
                        w_state_nxt = StHalt;
                    end else if (Ret) begin
                        if (w_empty) begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_nxt = 1'b1;
                        end else begin
                            w_pc_nxt  = w_top;
                            w_lvl_nxt = r_lvl - LVL_W'(1);
                        end
                    end else if (Call) begin
                        w_pc_nxt = Target;
                        if (w_full) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_push    = 1'b1;
                            w_lvl_nxt = r_lvl + LVL_W'(1);
                        end
                    end else if (BranchAbs) begin
                        w_pc_nxt = Target;
                    end else if (BranchRel && ALU_flag) begin
                        w_pc_nxt = w_pc_rel;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                default: w_state_nxt = StRun;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= StRun;
            r_pc    <= '0;
            r_lvl   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_lvl   <= w_lvl_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_push) begin
            r_ras[w_wr_idx] <= w_pc_inc;
        end
    end

    assign ProgCtr  = r_pc;
    assign Done     = (r_state == StHalt);
    assign StackErr = r_err;
    assign StackLvl = r_lvl;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: expected outputs are queued as each step is driven
// and popped for comparison once the DUT has updated.
module tb_prog_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] ProgSel;
    logic       Stall;
    logic       BranchAbs;
    logic       BranchRel;
    logic       Call;
    logic       Ret;
    logic       Halt;
    logic       ALU_flag;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic       Done;
    logic       StackErr;
    logic [2:0] StackLvl;

    typedef struct packed {
        logic [9:0] pc;
        logic [2:0] lvl;
        logic       err;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    prog_sequencer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .ProgSel  (ProgSel),
        .Stall    (Stall),
        .BranchAbs(BranchAbs),
        .BranchRel(BranchRel),
        .Call     (Call),
        .Ret      (Ret),
        .Halt     (Halt),
        .ALU_flag (ALU_flag),
        .Target   (Target),
        .ProgCtr  (ProgCtr),
        .Done     (Done),
        .StackErr (StackErr),
        .StackLvl (StackLvl)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t mk(input int pc, input int lvl, input bit err, input bit done);
        exp_t e;
        e.pc   = 10'(pc);
        e.lvl  = 3'(lvl);
        e.err  = err;
        e.done = done;
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        n_total++;
        assert (ProgCtr === e.pc) n_pass++;
        else $error("FAIL %s ProgCtr got %0d expected %0d", tag, ProgCtr, e.pc);
        n_total++;
        assert (StackLvl === e.lvl) n_pass++;
        else $error("FAIL %s StackLvl got %0d expected %0d", tag, StackLvl, e.lvl);
        n_total++;
        assert (StackErr === e.err) n_pass++;
        else $error("FAIL %s StackErr got %0b expected %0b", tag, StackErr, e.err);
        n_total++;
        assert (Done === e.done) n_pass++;
        else $error("FAIL %s Done got %0b expected %0b", tag, Done, e.done);
    endtask

    // Drive is already applied; expectation is for the state after the next edge.
    task automatic step(input string tag, input exp_t e);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        check(tag);
    endtask

    task automatic now(input string tag, input exp_t e);
        sb_q.push_back(e);
        check(tag);
    endtask

    task automatic idle();
        Start     = 1'b0;
        ProgSel   = 2'd0;
        Stall     = 1'b0;
        BranchAbs = 1'b0;
        BranchRel = 1'b0;
        Call      = 1'b0;
        Ret       = 1'b0;
        Halt      = 1'b0;
        ALU_flag  = 1'b0;
        Target    = 10'd0;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        idle();
        #3;
        now("reset", mk(0, 0, 0, 0));
        @(posedge Clk);
        #1;
        now("reset_held", mk(0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 1; i <= 5; i++) step("inc", mk(i, 0, 0, 0));

        Start = 1'b1; ProgSel = 2'd1;
        for (int i = 0; i < 3; i++) step("load1", mk(128, 0, 0, 0));
        idle();
        step("load_release", mk(128, 0, 0, 0));
        step("load_run", mk(129, 0, 0, 0));

        idle(); BranchAbs = 1'b1; Target = 10'd10;
        step("babs10", mk(10, 0, 0, 0));
        idle(); Call = 1'b1; Target = 10'd50;
        step("call50", mk(50, 1, 0, 0));
        idle();
        step("inc51", mk(51, 1, 0, 0));
        Ret = 1'b1;
        step("ret11", mk(11, 0, 0, 0));

        idle(); Call = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            Target = 10'(i * 100);
            step("call_nest", mk(i * 100, i, 0, 0));
        end
        Target = 10'd500;
        step("call_full", mk(500, 4, 1, 0));
        idle(); Ret = 1'b1;
        step("ret301", mk(301, 3, 1, 0));
        step("ret201", mk(201, 2, 1, 0));
        step("ret101", mk(101, 1, 1, 0));
        step("ret12", mk(12, 0, 1, 0));
        step("ret_empty", mk(13, 0, 1, 0));

        idle(); Start = 1'b1; ProgSel = 2'd3;
        step("load_oor", mk(0, 0, 0, 0));
        idle();
        step("load_oor_rel", mk(0, 0, 0, 0));

        BranchAbs = 1'b1; Target = 10'd5;
        step("babs5", mk(5, 0, 0, 0));
        idle(); BranchRel = 1'b1; ALU_flag = 1'b1; Target = 10'h3FD;
        step("brel_taken", mk(2, 0, 0, 0));
        idle(); BranchAbs = 1'b1; Target = 10'd5;
        step("babs5b", mk(5, 0, 0, 0));
        idle(); BranchRel = 1'b1; ALU_flag = 1'b0; Target = 10'h3FD;
        step("brel_nt", mk(6, 0, 0, 0));
        idle(); BranchAbs = 1'b1; Target = 10'd1023;
        step("babs1023", mk(1023, 0, 0, 0));
        idle();
        step("inc_wrap", mk(0, 0, 0, 0));
        BranchAbs = 1'b1; Target = 10'd1023;
        step("babs1023b", mk(1023, 0, 0, 0));
        idle(); Call = 1'b1; Target = 10'd7;
        step("call_wrap", mk(7, 1, 0, 0));
        idle(); Ret = 1'b1;
        step("ret_wrap", mk(0, 0, 0, 0));

        idle(); Stall = 1'b1; Halt = 1'b1; BranchAbs = 1'b1; Call = 1'b1; Target = 10'd77;
        step("stall_all", mk(0, 0, 0, 0));
        idle();
        step("inc1", mk(1, 0, 0, 0));
        Halt = 1'b1;
        step("halt", mk(1, 0, 0, 1));
        idle(); BranchAbs = 1'b1; Call = 1'b1; Target = 10'd77;
        step("halt_hold", mk(1, 0, 0, 1));
        step("halt_hold2", mk(1, 0, 0, 1));
        idle(); Start = 1'b1; ProgSel = 2'd2;
        step("halt_load2", mk(256, 0, 0, 0));
        idle();
        step("load2_rel", mk(256, 0, 0, 0));
        step("inc257", mk(257, 0, 0, 0));

        Call = 1'b1; Target = 10'd600;
        step("call600", mk(600, 1, 0, 0));
        idle();
        #1 Reset = 1'b0;
        #1 now("async_reset", mk(0, 0, 0, 0));
        #1 Reset = 1'b1;
        step("post_reset_inc", mk(1, 0, 0, 0));
        Ret = 1'b1;
        step("post_reset_ret", mk(2, 0, 1, 0));

        idle(); Start = 1'b1; ProgSel = 2'd1;
        step("load_before_rst", mk(128, 0, 0, 0));
        #1 Reset = 1'b0;
        #1 now("reset_in_load", mk(0, 0, 0, 0));
        Start = 1'b0;
        #1 Reset = 1'b1;
        step("run_after_load_rst", mk(1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
